// File: rtl/instr_encode_loader.sv
// Instruction encoder/loader: packs decoded instruction fields into 16-bit words
// and streams them into instruction memory from a programmable base address.
module instr_encode_loader #(
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_last,
    input  logic [3:0]        op,
    input  logic [2:0]        dest,
    input  logic [2:0]        q0,
    input  logic [2:0]        q1,
    input  logic [3:0]        immediate,
    input  logic [10:0]       immediate_b,
    input  logic              flag_en,
    input  logic              immed_sel,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_wdata,
    output logic [ADDR_W:0]   count,
    output logic              busy,
    output logic              done,
    output logic              overflow
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Count value held just before the DEPTH-th beat is accepted.
    localparam logic [ADDR_W:0] LAST_CNT = (ADDR_W+1)'(DEPTH - 1);

    function automatic logic [15:0] encode_word(
        input logic [3:0]  f_op,
        input logic [2:0]  f_dest,
        input logic [2:0]  f_q0,
        input logic [2:0]  f_q1,
        input logic [3:0]  f_imm,
        input logic [10:0] f_imm_b,
        input logic        f_flag_en,
        input logic        f_immed_sel
    );
        logic [15:0] word;
        if ((f_op == 4'b1011) || (f_op == 4'b1100) || (f_op == 4'b1101) || (f_op == 4'b1110)) begin
            word = {f_op, f_imm_b, f_immed_sel};
        end else if (f_immed_sel == 1'b0) begin
            word = {f_op, f_dest, f_q0, f_q1, 1'b0, f_flag_en, 1'b0};
        end else begin
            word = {f_op, f_dest, f_q0, f_imm, f_flag_en, 1'b1};
        end
        return word;
    endfunction

    state_t              state_r;
    state_t              state_next_s;
    logic                in_ready_s;
    logic                busy_s;
    logic                done_s;
    logic                accept_s;
    logic                start_acc_s;
    logic                depth_hit_s;
    logic [ADDR_W-1:0]   ptr_r;
    logic [ADDR_W:0]     count_r;
    logic                mem_we_r;
    logic [ADDR_W-1:0]   mem_addr_r;
    logic [15:0]         mem_wdata_r;
    logic                overflow_r;

    assign start_acc_s = (state_r == ST_IDLE) && start;
    assign accept_s    = in_valid && in_ready_s;
    assign depth_hit_s = accept_s && (count_r == LAST_CNT);

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_next_s = ST_LOAD;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (accept_s && (in_last || depth_hit_s)) begin
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_LOAD;
                end
            end
            ST_DONE: state_next_s = ST_IDLE;
            default: state_next_s = ST_IDLE;
        endcase
    end

    // State-decoded handshake and status outputs.
    always_comb begin
        in_ready_s = 1'b0;
        busy_s     = 1'b0;
        done_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                in_ready_s = 1'b0;
            end
            ST_LOAD: begin
                in_ready_s = 1'b1;
                busy_s     = 1'b1;
            end
            ST_DONE: begin
                done_s = 1'b1;
            end
            default: begin
                in_ready_s = 1'b0;
            end
        endcase
    end

    // Write pointer, registered memory write port, beat counter and sticky overflow.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr_r       <= {ADDR_W{1'b0}};
            count_r     <= {(ADDR_W+1){1'b0}};
            mem_we_r    <= 1'b0;
            mem_addr_r  <= {ADDR_W{1'b0}};
            mem_wdata_r <= 16'h0000;
            overflow_r  <= 1'b0;
        end else begin
            mem_we_r <= accept_s;
            if (start_acc_s) begin
                ptr_r      <= base_addr;
                count_r    <= {(ADDR_W+1){1'b0}};
                overflow_r <= 1'b0;
            end else if (accept_s) begin
                mem_addr_r  <= ptr_r;
                mem_wdata_r <= encode_word(op, dest, q0, q1, immediate, immediate_b,
                                           flag_en, immed_sel);
                ptr_r       <= ptr_r + ADDR_W'(1);
                count_r     <= count_r + (ADDR_W+1)'(1);
                if (depth_hit_s && !in_last) begin
                    overflow_r <= 1'b1;
                end
            end
        end
    end

    assign in_ready  = in_ready_s;
    assign busy      = busy_s;
    assign done      = done_s;
    assign mem_we    = mem_we_r;
    assign mem_addr  = mem_addr_r;
    assign mem_wdata = mem_wdata_r;
    assign count     = count_r;
    assign overflow  = overflow_r;

endmodule

// File: tb/tb_instr_encode_loader.sv
// Self-checking bench for instr_encode_loader: directed scenarios plus randomized
// sessions checked against an arithmetic reference of the instruction format.
module tb_instr_encode_loader;

    localparam int ADDR_W = 8;
    localparam int DEPTH  = 4;

    typedef struct {
        logic [3:0]  op;
        logic [2:0]  dest;
        logic [2:0]  q0;
        logic [2:0]  q1;
        logic [3:0]  imm;
        logic [10:0] immb;
        logic        fe;
        logic        isel;
    } beat_t;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] base_addr = '0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic              in_last = 1'b0;
    logic [3:0]        op = '0;
    logic [2:0]        dest = '0;
    logic [2:0]        q0 = '0;
    logic [2:0]        q1 = '0;
    logic [3:0]        immediate = '0;
    logic [10:0]       immediate_b = '0;
    logic              flag_en = 1'b0;
    logic              immed_sel = 1'b0;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [15:0]       mem_wdata;
    logic [ADDR_W:0]   count;
    logic              busy;
    logic              done;
    logic              overflow;

    int tests_run = 0;
    int tests_failed = 0;
    int wr_cnt = 0;
    beat_t beats [8];
    int    gaps  [8];

    instr_encode_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .base_addr(base_addr),
        .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
        .op(op), .dest(dest), .q0(q0), .q1(q1), .immediate(immediate),
        .immediate_b(immediate_b), .flag_en(flag_en), .immed_sel(immed_sel),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .count(count), .busy(busy), .done(done), .overflow(overflow)
    );

    always #5 clk = ~clk;

    // Count every write strobe seen on the memory port.
    always @(negedge clk) begin
        if (reset_n && mem_we) wr_cnt <= wr_cnt + 1;
    end

    // Instruction format from the field layout, built with plain arithmetic.
    function automatic int ref_enc(beat_t b);
        if (b.op >= 4'd11 && b.op <= 4'd14)
            return b.op * 4096 + b.immb * 2 + b.isel;
        else if (b.isel == 1'b0)
            return b.op * 4096 + b.dest * 512 + b.q0 * 64 + b.q1 * 8 + b.fe * 2;
        else
            return b.op * 4096 + b.dest * 512 + b.q0 * 64 + b.imm * 4 + b.fe * 2 + 1;
    endfunction

    task automatic check(input string tag, input int got, input int exp);
        tests_run++;
        assert (got === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input beat_t b, input logic last);
        op = b.op; dest = b.dest; q0 = b.q0; q1 = b.q1; immediate = b.imm;
        immediate_b = b.immb; flag_en = b.fe; immed_sel = b.isel;
        in_last = last; in_valid = 1'b1;
    endtask

    function automatic beat_t rand_beat();
        beat_t b;
        b.op = 4'($urandom); b.dest = 3'($urandom); b.q0 = 3'($urandom);
        b.q1 = 3'($urandom); b.imm = 4'($urandom); b.immb = 11'($urandom);
        b.fe = 1'($urandom); b.isel = 1'($urandom);
        return b;
    endfunction

    // One load session: n offered beats, in_last on beat last_idx, gaps[i] idle cycles before beat i.
    task automatic session(input logic [7:0] base, input int n, input int last_idx);
        int exp_n;
        int exp_ovf;
        int wr0;
        exp_ovf = (last_idx >= 0 && last_idx < DEPTH) ? 0 : 1;
        exp_n   = exp_ovf ? DEPTH : last_idx + 1;
        wr0 = wr_cnt;
        base_addr = base; start = 1'b1;
        step();
        start = 1'b0;
        check("start_busy", busy, 1);
        check("start_ready", in_ready, 1);
        check("start_count", count, 0);
        check("start_ovf", overflow, 0);
        for (int i = 0; i < n; i++) begin
            for (int g = 0; g < gaps[i]; g++) begin
                in_valid = 1'b0;
                step();
                if (i < exp_n) check("gap_no_we", mem_we, 0);
            end
            drive(beats[i], (i == last_idx));
            step();
            if (i < exp_n) begin
                check("we", mem_we, 1);
                check("addr", mem_addr, (base + i) % 256);
                check("wdata", mem_wdata, ref_enc(beats[i]));
                check("count", count, i + 1);
                if (i == exp_n - 1) begin
                    check("done_pulse", done, 1);
                    check("done_ready", in_ready, 0);
                    check("done_busy", busy, 0);
                    check("done_ovf", overflow, exp_ovf);
                end
            end else begin
                check("extra_no_we", mem_we, 0);
            end
        end
        in_valid = 1'b0; in_last = 1'b0;
        step();
        check("post_done", done, 0);
        check("post_we", mem_we, 0);
        check("post_ovf", overflow, exp_ovf);
        check("post_count", count, exp_n);
        check("write_total", wr_cnt - wr0, exp_n);
    endtask

    initial begin
        int wr0;
        int li;
        int n;
        for (int i = 0; i < 8; i++) begin
            gaps[i] = 0;
            beats[i] = rand_beat();
        end

        // Reset state.
        #3;
        check("rst_ready", in_ready, 0);
        check("rst_we", mem_we, 0);
        check("rst_addr", mem_addr, 0);
        check("rst_wdata", mem_wdata, 0);
        check("rst_count", count, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_ovf", overflow, 0);
        step();
        reset_n = 1'b1;
        step();

        // Register form, single beat.
        beats[0] = '{op:4'b0001, dest:3'd2, q0:3'd3, q1:3'd4, imm:4'd0, immb:11'd0, fe:1'b1, isel:1'b0};
        session(8'h10, 1, 0);

        // Immediate then branch form, back to back.
        beats[0] = '{op:4'b0010, dest:3'd1, q0:3'd5, q1:3'd7, imm:4'b1010, immb:11'd0, fe:1'b0, isel:1'b1};
        beats[1] = '{op:4'b1100, dest:3'd6, q0:3'd6, q1:3'd6, imm:4'hF, immb:11'h2AB, fe:1'b1, isel:1'b0};
        session(8'h20, 2, 1);

        // Gaps and address wrap.
        for (int i = 0; i < 3; i++) beats[i] = rand_beat();
        gaps[1] = 2;
        session(8'hFE, 3, 2);
        gaps[1] = 0;

        // Overflow at DEPTH, then overflow holds until the next start.
        for (int i = 0; i < 6; i++) beats[i] = rand_beat();
        session(8'h30, 6, -1);
        step();
        step();
        check("ovf_sticky", overflow, 1);
        beats[0] = rand_beat();
        session(8'h50, 1, 0);

        // Reset mid-session after two accepted beats.
        base_addr = 8'h60; start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            drive(beats[i], 1'b0);
            step();
        end
        reset_n = 1'b0;
        #1;
        check("arst_we", mem_we, 0);
        check("arst_busy", busy, 0);
        check("arst_count", count, 0);
        check("arst_ready", in_ready, 0);
        in_valid = 1'b0;
        step();
        reset_n = 1'b1;
        wr0 = wr_cnt;
        for (int i = 0; i < 4; i++) begin
            drive(beats[i], 1'b0);
            step();
            check("nostart_we", mem_we, 0);
            check("nostart_busy", busy, 0);
        end
        in_valid = 1'b0;
        step();
        check("nostart_writes", wr_cnt - wr0, 0);

        // start held high through a whole session.
        base_addr = 8'h40; start = 1'b1;
        step();
        check("hold_busy", busy, 1);
        drive(beats[0], 1'b0);
        step();
        check("hold_count1", count, 1);
        drive(beats[1], 1'b1);
        step();
        check("hold_count2", count, 2);
        check("hold_done", done, 1);
        in_valid = 1'b0; in_last = 1'b0;
        step();
        check("hold_idle_busy", busy, 0);
        check("hold_idle_done", done, 0);
        step();
        check("hold_restart_busy", busy, 1);
        check("hold_restart_count", count, 0);
        start = 1'b0;
        drive(beats[2], 1'b1);
        step();
        check("hold_restart_addr", mem_addr, 8'h40);
        check("hold_restart_wdata", mem_wdata, ref_enc(beats[2]));
        in_valid = 1'b0; in_last = 1'b0;
        step();

        // Randomized sessions.
        for (int s = 0; s < 25; s++) begin
            li = $urandom_range(0, 5);
            n = (li < DEPTH) ? li + 1 + $urandom_range(0, 1) : $urandom_range(DEPTH, 6);
            for (int i = 0; i < 8; i++) begin
                beats[i] = rand_beat();
                gaps[i] = $urandom_range(0, 2);
            end
            session(8'($urandom), n, li);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
